// File: rtl/stack_unit_if.sv
// stack_unit_if: decode-to-stack handshake plus the stack status bundle.
//   op_valid/op_ready/op_code/op_imm : micro-op issue handshake
//   err_clr                          : clears the sticky error flag
//   tos/nos/sp/torf/err              : stack status seen by the rest of the core
// master modport = decode side, slave modport = stack_unit.
interface stack_unit_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 256
);
  localparam int SPW = $clog2(DEPTH);

  logic             op_valid;
  logic             op_ready;
  logic [3:0]       op_code;
  logic [WIDTH-1:0] op_imm;
  logic             err_clr;
  logic [WIDTH-1:0] tos;
  logic [WIDTH-1:0] nos;
  logic [SPW:0]     sp;
  logic             torf;
  logic             err;

  modport master (
    output op_valid, op_code, op_imm, err_clr,
    input  op_ready, tos, nos, sp, torf, err
  );

  modport slave (
    input  op_valid, op_code, op_imm, err_clr,
    output op_ready, tos, nos, sp, torf, err
  );
endinterface

// File: rtl/stack_unit.sv
// stack_unit: operand-stack engine executing stack/ALU micro-ops.
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset, clears sp/torf/err/FSM
//   bus   : stack_unit_if.slave (op handshake, err_clr, tos/nos/sp/torf/err)
// Optional feature macro: STACK_BOUNDS_CHECK_EN enables overflow/underflow
// checking with sp spanning 0..DEPTH. Without it sp wraps modulo DEPTH and
// only illegal opcodes raise err.
//
// state | meaning
// IDLE  | op_ready=1, ops other than GET/PUT complete at the accept edge
// XFER  | op_ready=0, captured GET/PUT word is written at the next edge
module stack_unit #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 256
) (
  input logic         clk,
  input logic         reset,
  stack_unit_if.slave bus
);
  localparam int SPW = $clog2(DEPTH);
`ifdef STACK_BOUNDS_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  localparam logic [SPW:0] SP_FULL = (SPW+1)'(DEPTH);

  typedef enum logic {IDLE, XFER} state_t;

  state_t           state_q, state_d;
  logic             op_ready_q, op_ready_d;
  logic [SPW:0]     sp_q, sp_d, sp_nxt;
  logic             torf_q, torf_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] xfer_word_q, xfer_word_d;
  logic [SPW-1:0]   xfer_idx_q, xfer_idx_d;
  logic             xfer_push_q, xfer_push_d;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             mem_we;
  logic [SPW-1:0]   mem_widx;
  logic [WIDTH-1:0] mem_wdata;

  logic             accept, fault;
  logic [SPW:0]     k;
  logic [SPW-1:0]   sp_lo, idx_m1, idx_m2, idx_k;
  logic             sp_empty, sp_lt2, sp_full;
  logic [WIDTH-1:0] tos, nos, alu;

  assign accept   = bus.op_valid && op_ready_q;
  assign k        = bus.op_imm[SPW:0];
  assign sp_lo    = sp_q[SPW-1:0];
  // All array indices wrap modulo DEPTH; with checking enabled the guards
  // guarantee they never actually wrap.
  assign idx_m1   = sp_lo - SPW'(1);
  assign idx_m2   = sp_lo - SPW'(2);
  assign idx_k    = sp_lo - SPW'(1) - k[SPW-1:0];
  assign sp_empty = (sp_q == '0);
  assign sp_lt2   = (sp_q < (SPW+1)'(2));
  assign sp_full  = (sp_q == SP_FULL);

  assign tos = sp_empty ? '0 : mem_q[idx_m1];
  assign nos = sp_lt2   ? '0 : mem_q[idx_m2];

  always_comb begin
    alu = '0;
    case (bus.op_code)
      4'h6:    alu = nos + tos;
      4'h7:    alu = nos - tos;
      4'h8:    alu = nos & tos;
      4'h9:    alu = nos | tos;
      4'hA:    alu = nos ^ tos;
      4'hB:    alu = {{(WIDTH-1){1'b0}}, (nos < tos)};
      default: alu = '0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    op_ready_d  = op_ready_q;
    sp_nxt      = sp_q;
    torf_d      = torf_q;
    err_d       = err_q;
    xfer_word_d = xfer_word_q;
    xfer_idx_d  = xfer_idx_q;
    xfer_push_d = xfer_push_q;
    mem_we      = 1'b0;
    mem_widx    = sp_lo;
    mem_wdata   = bus.op_imm;
    fault       = 1'b0;

    if (bus.err_clr) err_d = 1'b0;

    if (state_q == XFER) begin
      mem_we     = 1'b1;
      mem_widx   = xfer_idx_q;
      mem_wdata  = xfer_word_q;
      if (xfer_push_q) sp_nxt = sp_q + (SPW+1)'(1);
      state_d    = IDLE;
      op_ready_d = 1'b1;
    end else if (accept) begin
      case (bus.op_code)
        4'h1: begin
          if (CHK && sp_full) fault = 1'b1;
          else begin
            mem_we = 1'b1;
            sp_nxt = sp_q + (SPW+1)'(1);
          end
        end
        4'h2: begin
          // An over-deep POP is flagged but still empties the stack.
          if (CHK && (k > sp_q)) begin
            fault  = 1'b1;
            sp_nxt = '0;
          end else begin
            sp_nxt = sp_q - k;
          end
        end
        4'h3: begin
          if (CHK && (sp_full || sp_empty)) fault = 1'b1;
          else begin
            mem_we    = 1'b1;
            mem_wdata = tos;
            sp_nxt    = sp_q + (SPW+1)'(1);
          end
        end
        4'h4: begin
          if (CHK && (sp_full || (k >= sp_q))) fault = 1'b1;
          else begin
            xfer_word_d = mem_q[idx_k];
            xfer_idx_d  = sp_lo;
            xfer_push_d = 1'b1;
            state_d     = XFER;
            op_ready_d  = 1'b0;
          end
        end
        4'h5: begin
          if (CHK && (k >= sp_q)) fault = 1'b1;
          else begin
            xfer_word_d = tos;
            xfer_idx_d  = idx_k;
            xfer_push_d = 1'b0;
            state_d     = XFER;
            op_ready_d  = 1'b0;
          end
        end
        4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB: begin
          if (CHK && sp_lt2) fault = 1'b1;
          else begin
            mem_we    = 1'b1;
            mem_widx  = idx_m2;
            mem_wdata = alu;
            sp_nxt    = sp_q - (SPW+1)'(1);
          end
        end
        4'hC: begin
          if (CHK && sp_empty) fault = 1'b1;
          else begin
            torf_d = (tos != '0);
            sp_nxt = sp_q - (SPW+1)'(1);
          end
        end
        4'hD:    sp_nxt = '0;
        4'hE,
        4'hF:    fault = 1'b1;
        default: ;
      endcase
    end

    // A new fault wins over a same-cycle clear.
    if (fault) err_d = 1'b1;

`ifdef STACK_BOUNDS_CHECK_EN
    sp_d = sp_nxt;
`else
    sp_d = {1'b0, sp_nxt[SPW-1:0]};
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      op_ready_q  <= 1'b1;
      sp_q        <= '0;
      torf_q      <= 1'b0;
      err_q       <= 1'b0;
      xfer_word_q <= '0;
      xfer_idx_q  <= '0;
      xfer_push_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_ready_q  <= op_ready_d;
      sp_q        <= sp_d;
      torf_q      <= torf_d;
      err_q       <= err_d;
      xfer_word_q <= xfer_word_d;
      xfer_idx_q  <= xfer_idx_d;
      xfer_push_q <= xfer_push_d;
    end
  end

  // Array is not reset; an XFER aborted by reset never writes because
  // state_q is forced back to IDLE asynchronously.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_widx] <= mem_wdata;
  end

  assign bus.op_ready = op_ready_q;
  assign bus.tos      = tos;
  assign bus.nos      = nos;
  assign bus.sp       = sp_q;
  assign bus.torf     = torf_q;
  assign bus.err      = err_q;
endmodule

// File: tb/tb_stack_unit.sv
module tb_stack_unit;
  localparam int W   = 16;
  localparam int D   = 8;
  localparam int SPW = $clog2(D);
`ifdef STACK_BOUNDS_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b0;

  stack_unit_if #(.WIDTH(W), .DEPTH(D)) bus ();
  stack_unit #(.WIDTH(W), .DEPTH(D)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: the stack as a plain array plus a live-entry count.
  logic [W-1:0] m_mem [D];
  int           m_sp;
  bit           m_torf, m_err;

  typedef struct {
    logic [3:0]   code;
    logic [W-1:0] imm;
    logic [W-1:0] tos;
    logic [W-1:0] nos;
    int           sp;
    bit           torf;
  } vec_t;

  vec_t tbl [33];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int wrapi(input int i);
    return ((i % D) + D) % D;
  endfunction

  function automatic logic [W-1:0] m_tos();
    return (m_sp == 0) ? '0 : m_mem[wrapi(m_sp - 1)];
  endfunction

  function automatic logic [W-1:0] m_nos();
    return (m_sp < 2) ? '0 : m_mem[wrapi(m_sp - 2)];
  endfunction

  task automatic model_op(input logic [3:0] c, input logic [W-1:0] imm, input bit clr,
                          output bit xfer);
    int           k;
    bit           f;
    logic [W-1:0] t, n, r;
    k = int'(imm[SPW:0]);
    f = 1'b0;
    xfer = 1'b0;
    t = m_tos();
    n = m_nos();
    r = '0;
    case (c)
      4'h1: if (CHK && m_sp == D) f = 1'b1;
            else begin m_mem[wrapi(m_sp)] = imm; m_sp++; end
      4'h2: if (CHK && k > m_sp) begin f = 1'b1; m_sp = 0; end
            else m_sp = m_sp - k;
      4'h3: if (CHK && (m_sp == D || m_sp < 1)) f = 1'b1;
            else begin m_mem[wrapi(m_sp)] = t; m_sp++; end
      4'h4: if (CHK && (m_sp == D || k >= m_sp)) f = 1'b1;
            else begin
              m_mem[wrapi(m_sp)] = m_mem[wrapi(m_sp - 1 - k)];
              m_sp++;
              xfer = 1'b1;
            end
      4'h5: if (CHK && k >= m_sp) f = 1'b1;
            else begin m_mem[wrapi(m_sp - 1 - k)] = t; xfer = 1'b1; end
      4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB: begin
        if (CHK && m_sp < 2) f = 1'b1;
        else begin
          case (c)
            4'h6:    r = n + t;
            4'h7:    r = n - t;
            4'h8:    r = n & t;
            4'h9:    r = n | t;
            4'hA:    r = n ^ t;
            default: r = (n < t) ? W'(1) : W'(0);
          endcase
          m_mem[wrapi(m_sp - 2)] = r;
          m_sp--;
        end
      end
      4'hC: if (CHK && m_sp < 1) f = 1'b1;
            else begin m_torf = (t != 0); m_sp--; end
      4'hD: m_sp = 0;
      4'hE, 4'hF: f = 1'b1;
      default: ;
    endcase
    if (!CHK) m_sp = wrapi(m_sp);
    m_err = (m_err && !clr) || f;
  endtask

  task automatic check_model(input string tag);
    check({tag, "_tos"},   32'(bus.tos),      32'(m_tos()));
    check({tag, "_nos"},   32'(bus.nos),      32'(m_nos()));
    check({tag, "_sp"},    32'(bus.sp),       32'(m_sp));
    check({tag, "_torf"},  32'(bus.torf),     32'(m_torf));
    check({tag, "_err"},   32'(bus.err),      32'(m_err));
    check({tag, "_ready"}, 32'(bus.op_ready), 32'd1);
  endtask

  task automatic do_op(input logic [3:0] c, input logic [W-1:0] imm, input bit clr);
    bit xf;
    bus.op_valid = 1'b1;
    bus.op_code  = c;
    bus.op_imm   = imm;
    bus.err_clr  = clr;
    @(posedge clk); #1;
    bus.op_valid = 1'b0;
    bus.err_clr  = 1'b0;
    model_op(c, imm, clr, xf);
    if (xf) begin
      check($sformatf("xfer_ready_low_op%0h", c), 32'(bus.op_ready), 32'd0);
      @(posedge clk); #1;
    end
    check_model($sformatf("op%0h", c));
  endtask

  task automatic apply_reset();
    bus.op_valid = 1'b0;
    bus.op_code  = 4'h0;
    bus.op_imm   = '0;
    bus.err_clr  = 1'b0;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 32'(bus.op_ready), 32'd1);
    check("rst_sp",    32'(bus.sp),       32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    m_sp = 0;
    m_torf = 1'b0;
    m_err = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{4'h1, 16'd5,      16'd5,      16'd0,      1, 1'b0};
    tbl[1]  = '{4'h1, 16'd3,      16'd3,      16'd5,      2, 1'b0};
    tbl[2]  = '{4'h7, 16'd0,      16'd2,      16'd0,      1, 1'b0};
    tbl[3]  = '{4'h1, 16'hFFFF,   16'hFFFF,   16'd2,      2, 1'b0};
    tbl[4]  = '{4'h6, 16'd0,      16'd1,      16'd0,      1, 1'b0};
    tbl[5]  = '{4'hD, 16'd0,      16'd0,      16'd0,      0, 1'b0};
    tbl[6]  = '{4'h1, 16'd10,     16'd10,     16'd0,      1, 1'b0};
    tbl[7]  = '{4'h1, 16'd20,     16'd20,     16'd10,     2, 1'b0};
    tbl[8]  = '{4'h1, 16'd30,     16'd30,     16'd20,     3, 1'b0};
    tbl[9]  = '{4'h4, 16'd2,      16'd10,     16'd30,     4, 1'b0};
    tbl[10] = '{4'h5, 16'd1,      16'd10,     16'd10,     4, 1'b0};
    tbl[11] = '{4'h1, 16'd0,      16'd0,      16'd10,     5, 1'b0};
    tbl[12] = '{4'hC, 16'd0,      16'd10,     16'd10,     4, 1'b0};
    tbl[13] = '{4'h1, 16'd7,      16'd7,      16'd10,     5, 1'b0};
    tbl[14] = '{4'hC, 16'd0,      16'd10,     16'd10,     4, 1'b1};
    tbl[15] = '{4'h3, 16'd0,      16'd10,     16'd10,     5, 1'b1};
    tbl[16] = '{4'hD, 16'd0,      16'd0,      16'd0,      0, 1'b1};
    tbl[17] = '{4'h1, 16'd3,      16'd3,      16'd0,      1, 1'b1};
    tbl[18] = '{4'h1, 16'd9,      16'd9,      16'd3,      2, 1'b1};
    tbl[19] = '{4'hB, 16'd0,      16'd1,      16'd0,      1, 1'b1};
    tbl[20] = '{4'h1, 16'hF0F0,   16'hF0F0,   16'd1,      2, 1'b1};
    tbl[21] = '{4'h1, 16'h3C3C,   16'h3C3C,   16'hF0F0,   3, 1'b1};
    tbl[22] = '{4'h8, 16'd0,      16'h3030,   16'd1,      2, 1'b1};
    tbl[23] = '{4'h1, 16'h0F0F,   16'h0F0F,   16'h3030,   3, 1'b1};
    tbl[24] = '{4'h9, 16'd0,      16'h3F3F,   16'd1,      2, 1'b1};
    tbl[25] = '{4'h1, 16'h00FF,   16'h00FF,   16'h3F3F,   3, 1'b1};
    tbl[26] = '{4'hA, 16'd0,      16'h3FC0,   16'd1,      2, 1'b1};
    tbl[27] = '{4'h0, 16'd0,      16'h3FC0,   16'd1,      2, 1'b1};
    tbl[28] = '{4'h2, 16'd1,      16'd1,      16'd0,      1, 1'b1};
    tbl[29] = '{4'h1, 16'd5,      16'd5,      16'd1,      2, 1'b1};
    tbl[30] = '{4'h7, 16'd0,      16'hFFFC,   16'd0,      1, 1'b1};
    tbl[31] = '{4'h1, 16'd2,      16'd2,      16'hFFFC,   2, 1'b1};
    tbl[32] = '{4'hB, 16'd0,      16'd0,      16'd0,      1, 1'b1};

    apply_reset();
    check("reset_tos",   32'(bus.tos),      32'd0);
    check("reset_nos",   32'(bus.nos),      32'd0);
    check("reset_sp",    32'(bus.sp),       32'd0);
    check("reset_torf",  32'(bus.torf),     32'd0);
    check("reset_err",   32'(bus.err),      32'd0);
    check("reset_ready", 32'(bus.op_ready), 32'd1);

    for (int i = 0; i < 33; i++) begin
      do_op(tbl[i].code, tbl[i].imm, 1'b0);
      check($sformatf("tbl%0d_tos", i),  32'(bus.tos),  32'(tbl[i].tos));
      check($sformatf("tbl%0d_nos", i),  32'(bus.nos),  32'(tbl[i].nos));
      check($sformatf("tbl%0d_sp", i),   32'(bus.sp),   32'(tbl[i].sp));
      check($sformatf("tbl%0d_torf", i), 32'(bus.torf), 32'(tbl[i].torf));
      check($sformatf("tbl%0d_err", i),  32'(bus.err),  32'd0);
    end

`ifdef STACK_BOUNDS_CHECK_EN
    do_op(4'hD, '0, 1'b0);
    for (int i = 1; i <= D; i++) do_op(4'h1, W'(i), 1'b0);
    check("full_sp", 32'(bus.sp), 32'(D));
    do_op(4'h1, 16'd99, 1'b0);
    check("ovf_err", 32'(bus.err), 32'd1);
    check("ovf_sp",  32'(bus.sp),  32'(D));
    check("ovf_tos", 32'(bus.tos), 32'(D));
    do_op(4'h0, '0, 1'b1);
    check("clr_err", 32'(bus.err), 32'd0);
    do_op(4'h2, W'(D + 3), 1'b0);
    check("pop_clamp_sp",  32'(bus.sp),  32'd0);
    check("pop_clamp_err", 32'(bus.err), 32'd1);
    do_op(4'h6, '0, 1'b0);
    check("add_empty_err", 32'(bus.err), 32'd1);
    check("add_empty_sp",  32'(bus.sp),  32'd0);
    do_op(4'h0, '0, 1'b1);
    do_op(4'h6, '0, 1'b1);
    check("clr_vs_fault_err", 32'(bus.err), 32'd1);
    do_op(4'h1, 16'd4, 1'b1);
    do_op(4'h4, 16'd1, 1'b0);
    check("get_under_err", 32'(bus.err), 32'd1);
    check("get_under_sp",  32'(bus.sp),  32'd1);
`else
    do_op(4'hD, '0, 1'b0);
    for (int i = 1; i <= D + 1; i++) do_op(4'h1, W'(i), 1'b0);
    check("wrap_sp",  32'(bus.sp),  32'd1);
    check("wrap_tos", 32'(bus.tos), 32'(D + 1));
    do_op(4'hE, '0, 1'b0);
    check("illegal_err", 32'(bus.err), 32'd1);
    check("illegal_sp",  32'(bus.sp),  32'd1);
    do_op(4'hF, '0, 1'b1);
    check("clr_vs_illegal_err", 32'(bus.err), 32'd1);
    do_op(4'h0, '0, 1'b1);
    check("clr_err", 32'(bus.err), 32'd0);
    do_op(4'h2, 16'd3, 1'b0);
    check("pop_wrap_sp",  32'(bus.sp),  32'(D - 2));
    check("pop_wrap_tos", 32'(bus.tos), 32'(D - 2));
`endif

    // Reset in the middle of a GET: the pending write must be dropped.
    do_op(4'hD, '0, 1'b0);
    do_op(4'h1, 16'd10, 1'b0);
    do_op(4'h1, 16'd20, 1'b0);
    do_op(4'h1, 16'd30, 1'b0);
    do_op(4'h1, 16'd99, 1'b0);
    do_op(4'h2, 16'd1, 1'b0);
    do_op(4'hE, '0, 1'b0);
    bus.op_valid = 1'b1;
    bus.op_code  = 4'h4;
    bus.op_imm   = 16'd2;
    @(posedge clk); #1;
    bus.op_valid = 1'b0;
    check("midget_ready_low", 32'(bus.op_ready), 32'd0);
    #2 reset = 1'b0;
    #1;
    check("abort_ready", 32'(bus.op_ready), 32'd1);
    check("abort_sp",    32'(bus.sp),       32'd0);
    check("abort_err",   32'(bus.err),      32'd0);
    check("abort_tos",   32'(bus.tos),      32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    m_sp = 0;
    m_torf = 1'b0;
    m_err = 1'b0;
    check_model("after_abort");
`ifndef STACK_BOUNDS_CHECK_EN
    do_op(4'h4, 16'd4, 1'b0);
    check("no_abort_write", 32'(bus.tos), 32'd99);
`endif

    // Fill every entry so random GETs never read unwritten storage.
    do_op(4'hD, '0, 1'b0);
    for (int i = 0; i < D; i++) do_op(4'h1, W'($urandom), 1'b0);
    do_op(4'hD, '0, 1'b0);

    for (int i = 0; i < 400; i++) begin
      logic [3:0]   c;
      logic [W-1:0] imm;
      bit           clr;
      c   = ($urandom_range(0, 9) < 3) ? 4'h1 : 4'($urandom_range(0, 15));
      imm = ($urandom_range(0, 3) == 0) ? W'($urandom) : W'($urandom_range(0, D + 2));
      clr = ($urandom_range(0, 7) == 0);
      do_op(c, imm, clr);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
